// File: rtl/mmio_bridge_if.sv
// Bus bundle for mmio_bridge: datapath request, RAM port, and the two byte streams.
// master is the surrounding system (datapath, RAM, stream peers); slave is the bridge.
interface mmio_bridge_if;
  // Datapath data-memory request
  logic [7:0] Addr;
  logic [7:0] WrData;
  logic       MemWrite;
  logic       MemRead;
  logic [7:0] RdData;

  // RAM-side port
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_rdata;

  // Output byte stream
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // Input byte stream
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output Addr,
    output WrData,
    output MemWrite,
    output MemRead,
    input  RdData,
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    input  ram_re,
    output ram_rdata,
    input  out_data,
    input  out_valid,
    output out_ready,
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  Addr,
    input  WrData,
    input  MemWrite,
    input  MemRead,
    output RdData,
    output ram_addr,
    output ram_wdata,
    output ram_we,
    output ram_re,
    input  ram_rdata,
    output out_data,
    output out_valid,
    input  out_ready,
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO bridge: passes 0x00-0xFB through to RAM and decodes 0xFC-0xFF into a free-running
// counter, a one-byte input buffer, a status register and a 4-entry output FIFO.
module mmio_bridge (
  input logic          CLK,
  input logic          Reset,
  mmio_bridge_if.slave bus
);

  localparam logic [7:0] AddrCnt    = 8'hFC;
  localparam logic [7:0] AddrInbuf  = 8'hFD;
  localparam logic [7:0] AddrStatus = 8'hFE;
  localparam logic [7:0] AddrOut    = 8'hFF;
  localparam int unsigned Depth     = 4;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] inbuf_q, inbuf_d;
  logic       inflag_q, inflag_d;
  logic       ovf_q, ovf_d;
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] count_q, count_d;
  logic [7:0] mem_q [Depth];
  logic [7:0] mem_d [Depth];

  logic       is_mmio;
  logic       wr_cnt;
  logic       rd_inbuf;
  logic       wr_status;
  logic       push;
  logic       pop;
  logic       push_ok;
  logic       full;
  logic       empty;
  logic       capture;
  logic [7:0] status;

  // Top four addresses form the MMIO window.
  assign is_mmio = (bus.Addr[7:2] == 6'b111111);

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);

  // Both stream handshakes are held off while Reset is high.
  assign bus.out_valid = ~empty & ~Reset;
  assign bus.in_ready  = ~inflag_q & ~Reset;
  assign bus.out_data  = mem_q[rptr_q];

  assign wr_cnt    = bus.MemWrite & (bus.Addr == AddrCnt)    & ~Reset;
  assign rd_inbuf  = bus.MemRead  & (bus.Addr == AddrInbuf)  & ~Reset;
  assign wr_status = bus.MemWrite & (bus.Addr == AddrStatus) & ~Reset;
  assign push      = bus.MemWrite & (bus.Addr == AddrOut)    & ~Reset;
  assign pop       = bus.out_valid & bus.out_ready;
  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign push_ok   = push & (~full | pop);
  assign capture   = bus.in_valid & bus.in_ready;

  assign status = {ovf_q, inflag_q, full, empty, 1'b0, count_q};

  // RAM side: address/data always pass through, strobes only inside the RAM window.
  always_comb begin
    bus.ram_addr  = bus.Addr;
    bus.ram_wdata = bus.WrData;
    bus.ram_we    = bus.MemWrite & ~is_mmio;
    bus.ram_re    = bus.MemRead & ~is_mmio;
  end

  always_comb begin
    bus.RdData = bus.ram_rdata;
    case (bus.Addr)
      AddrCnt:    bus.RdData = cnt_q;
      AddrInbuf:  bus.RdData = inbuf_q;
      AddrStatus: bus.RdData = status;
      AddrOut:    bus.RdData = 8'h00;
      default:    bus.RdData = bus.ram_rdata;
    endcase
  end

  // Counter: a write load wins over the increment.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (wr_cnt) begin
      cnt_d = bus.WrData;
    end
  end

  // Input buffer: capture is impossible while INFLAG is set, so clear and set never collide.
  always_comb begin
    inbuf_d  = inbuf_q;
    inflag_d = inflag_q;
    if (rd_inbuf) begin
      inflag_d = 1'b0;
    end
    if (capture) begin
      inbuf_d  = bus.in_data;
      inflag_d = 1'b1;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mem_d   = mem_q;

    if (push_ok) begin
      mem_d[wptr_q] = bus.WrData;
      wptr_d        = wptr_q + 2'd1;
    end
    if (pop) begin
      rptr_d = rptr_q + 2'd1;
    end

    if (push_ok && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 3'd1;
    end

    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (wr_status && bus.WrData[7]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q    <= 8'h00;
      inbuf_q  <= 8'h00;
      inflag_q <= 1'b0;
      ovf_q    <= 1'b0;
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      cnt_q    <= cnt_d;
      inbuf_q  <= inbuf_d;
      inflag_q <= inflag_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge; output-stream bytes are checked against a scoreboard queue
// filled as OUTDATA writes are issued.
module tb_mmio_bridge;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  logic [7:0] exp_q [$];

  mmio_bridge_if bus ();

  mmio_bridge u_dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational peek of an address with no side effects (MemRead low).
  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.Addr     = a;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    #1;
    check(tag, bus.RdData, exp);
  endtask

  task automatic mmio_write(input logic [7:0] a, input logic [7:0] d);
    bus.Addr     = a;
    bus.WrData   = d;
    bus.MemWrite = 1'b1;
    bus.MemRead  = 1'b0;
    if (a == 8'hFF && !rst && (exp_q.size() < 4 || bus.out_ready)) exp_q.push_back(d);
    tick();
    bus.MemWrite = 1'b0;
  endtask

  task automatic read_inbuf(input logic [7:0] exp, input string tag);
    bus.Addr    = 8'hFD;
    bus.MemRead = 1'b1;
    #1;
    check(tag, bus.RdData, exp);
    tick();
    bus.MemRead = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
    bus.out_ready = 1'b0;
  endtask

  // Output-stream monitor: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      pops++;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL out_unexpected: observed=0x%0h expected=none", bus.out_data);
      end
      if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.Addr      = 8'h00;
    bus.WrData    = 8'h00;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.ram_rdata = 8'h00;
    bus.out_ready = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    tick();
    tick();

    // Reset behaviour: streams held off, RAM passthrough alive, MMIO writes ignored.
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    bus.Addr     = 8'h03;
    bus.MemWrite = 1'b1;
    #1;
    check("rst_ram_we", bus.ram_we, 1'b1);
    mmio_write(8'hFF, 8'hEE);
    rst = 1'b0;
    peek(8'hFE, 8'h10, "rst_status");
    peek(8'hFC, 8'h00, "rst_cnt");
    check("rst_in_ready_after", bus.in_ready, 1'b1);

    // Two pushes with the sink stalled, then drain in order.
    bus.Addr     = 8'hFF;
    bus.WrData   = 8'h41;
    bus.MemWrite = 1'b1;
    #1;
    check("no_bypass", bus.out_valid, 1'b0);
    exp_q.push_back(8'h41);
    tick();
    bus.MemWrite = 1'b0;
    peek(8'hFE, 8'h01, "status_one");
    check("valid_after_push", bus.out_valid, 1'b1);
    mmio_write(8'hFF, 8'h42);
    peek(8'hFE, 8'h02, "status_two");
    check("head_hold", bus.out_data, 8'h41);
    pops = 0;
    drain("drain_two");
    check("pops_two", pops, 2);
    check("valid_fall", bus.out_valid, 1'b0);
    peek(8'hFE, 8'h10, "status_drained");

    // Overflow: fifth byte dropped, OVF sticky until cleared through STATUS.
    for (int i = 1; i <= 5; i++) mmio_write(8'hFF, 8'(i));
    peek(8'hFE, 8'hA4, "status_ovf");
    mmio_write(8'hFE, 8'h80);
    peek(8'hFE, 8'h24, "status_ovf_clr");
    pops = 0;
    drain("drain_ovf");
    check("pops_ovf", pops, 4);
    check("valid_after_ovf", bus.out_valid, 1'b0);

    // Push and pop on the same edge while full.
    for (int i = 0; i < 4; i++) mmio_write(8'hFF, 8'(8'h10 + i));
    peek(8'hFE, 8'h24, "status_full");
    pops = 0;
    bus.out_ready = 1'b1;
    mmio_write(8'hFF, 8'hFF);
    peek(8'hFE, 8'h24, "status_push_pop");
    drain("drain_push_pop");
    check("pops_push_pop", pops, 5);

    // Input capture and clear.
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    #1;
    check("in_ready_idle", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h77;
    check("in_ready_held", bus.in_ready, 1'b0);
    peek(8'hFE, 8'h50, "status_inflag");
    read_inbuf(8'h5A, "inbuf_5a");
    check("in_ready_back", bus.in_ready, 1'b1);
    peek(8'hFE, 8'h10, "status_inflag_clr");

    // Clear beats a same-cycle offer; capture follows on the next edge.
    bus.in_data  = 8'h33;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'h66;
    read_inbuf(8'h33, "inbuf_33");
    check("in_ready_reopen", bus.in_ready, 1'b1);
    peek(8'hFD, 8'h33, "inbuf_no_capture");
    tick();
    bus.in_valid = 1'b0;
    check("in_ready_recap", bus.in_ready, 1'b0);
    peek(8'hFD, 8'h66, "inbuf_66");

    // Counter load and wrap, RAM strobes.
    bus.Addr     = 8'hFC;
    bus.WrData   = 8'hFE;
    bus.MemWrite = 1'b1;
    #1;
    check("cnt_no_ram_we", bus.ram_we, 1'b0);
    tick();
    bus.MemWrite = 1'b0;
    peek(8'hFC, 8'hFE, "cnt_load");
    tick();
    peek(8'hFC, 8'hFF, "cnt_plus1");
    tick();
    peek(8'hFC, 8'h00, "cnt_wrap");
    bus.Addr     = 8'h03;
    bus.WrData   = 8'h9C;
    bus.MemWrite = 1'b1;
    #1;
    check("ram_we", bus.ram_we, 1'b1);
    check("ram_addr", bus.ram_addr, 8'h03);
    check("ram_wdata", bus.ram_wdata, 8'h9C);
    bus.MemWrite  = 1'b0;
    bus.Addr      = 8'h10;
    bus.MemRead   = 1'b1;
    bus.ram_rdata = 8'hC3;
    #1;
    check("ram_re", bus.ram_re, 1'b1);
    check("ram_rdata", bus.RdData, 8'hC3);
    bus.Addr = 8'hFC;
    #1;
    check("mmio_no_ram_re", bus.ram_re, 1'b0);
    bus.MemRead = 1'b0;
    peek(8'hFF, 8'h00, "outdata_read");

    // Reset mid-stream with COUNT=3, OVF=1, INFLAG=1.
    for (int i = 0; i < 5; i++) mmio_write(8'hFF, 8'(8'hA0 + i));
    peek(8'hFE, 8'hE4, "status_pre_pop");
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    peek(8'hFE, 8'hC3, "status_pre_reset");
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    tick();
    exp_q.delete();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    peek(8'hFE, 8'h10, "post_rst_status");
    check("post_rst_out_valid", bus.out_valid, 1'b0);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    peek(8'hFD, 8'h00, "post_rst_inbuf");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
